mux_2v1: RTL and testbench
==========================

MUX_2V1 -- requirements
Module: mux_2v1

Interface
REQ-001: Parameter WIDTH, default 1; SHALL set the bit width of A, B, S and S_q.
REQ-002: Parameter CNT_W, default 16; SHALL set the width of sel_changes.
REQ-003: clk  input  1; SHALL be the single clock, with all state updated on its rising edge.
REQ-004: rst_n  input  1; reset is synchronous and active-low.
REQ-005: A  input  WIDTH; SHALL be data input 0.
REQ-006: B  input  WIDTH; SHALL be data input 1.
REQ-007: sel  input  1; SHALL be the select line (0 selects A, 1 selects B).
REQ-008: en  input  1; SHALL be the capture enable for the registered path.
REQ-009: S  output  WIDTH; SHALL be the combinational mux output.
REQ-010: S_q  output  WIDTH; SHALL be the registered mux output.
REQ-011: S_valid  output  1; SHALL be high when S_q holds a value captured since reset.
REQ-012: sel_changes  output  CNT_W; SHALL count the sel transitions seen at clock edges.

Function
REQ-013: S SHALL equal A when sel=0 and B when sel=1, bitwise and purely combinational, with zero-cycle latency and no dependence on clk, rst_n or en.
REQ-014: S SHALL follow input changes within the same delta/settle time, including while rst_n=0.
REQ-015: sel X/Z handling: S SHALL be driven X in simulation; synthesis treats it as don't-care.
REQ-016: On a rising clk edge with rst_n=1 and en=1, S_q SHALL load the value (sel ? B : A) sampled at that edge, giving 1-cycle latency.
REQ-017: On a rising clk edge with rst_n=1 and en=0, S_q SHALL hold its value.
REQ-018: S_valid SHALL set to 1 on the first enabled capture after reset and SHALL stay 1 until the next reset.
REQ-019: An internal register sel_d SHALL store sel at each clk edge with rst_n=1.
REQ-020: sel_changes SHALL increment by 1 at each edge where sel differs from sel_d, independent of en.
REQ-021: sel_changes SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022: The first edge after reset release SHALL compare sel against sel_d's reset value of 0.
REQ-023: Simultaneous events: an edge carrying both a sel change and en=1 SHALL perform both the capture (using the new sel) and the count increment.

Reset
REQ-024: While rst_n=0 at a rising clk edge, S_q SHALL be set to 0, S_valid to 0, sel_changes to 0, and sel_d to 0.
REQ-025: Reset SHALL take priority over en and over counting.
REQ-026: Reset asserted mid-operation SHALL clear all registers at the next edge, and S SHALL remain combinationally correct throughout.
REQ-027: No register SHALL change on rst_n edges alone; reset is synchronous.

Verification
REQ-028: Exhaustive combinational check with WIDTH=1: for all (A,B) in {00,01,10,11} and sel in {1,0}, S SHALL equal B when sel=1 and A when sel=0.
REQ-029: Registered path: A=0x0, B=0x1, sel=1, en=1, one edge -> S_q=1 and S_valid=1; then en=0, sel=0, one edge -> S_q stays 1.
REQ-030: Reset: from S_q=1, sel_changes=3, hold rst_n=0 for one edge -> S_q=0, S_valid=0, sel_changes=0, while S still tracks the inputs.
REQ-031: Counter: toggle sel on every edge for 5 edges after reset, starting from sel=1 -> sel_changes=5; with CNT_W=2, 5 toggles -> sel_changes=3 (saturated).
REQ-032: Width: WIDTH=8, A=0xA5, B=0x3C -> S=0xA5 with sel=0 and S=0x3C with sel=1; with en=1 and sel=1, S_q=0x3C one edge later.

Source files
------------

// File: rtl/mux_2v1.sv
// rtl/mux_2v1.sv - 2:1 mux with registered copy, valid flag and select-change counter

module mux_2v1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] S_q,
  output logic             S_valid,
  output logic [CNT_W-1:0] sel_changes
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s_reg_q, s_reg_d;
  logic             valid_q, valid_d;
  logic             sel_d_q, sel_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational select; an unknown select propagates X so it is visible in simulation
  always_comb begin
    S = A;
    case (sel)
      1'b0:    S = A;
      1'b1:    S = B;
      default: S = {WIDTH{1'bx}};
    endcase
  end

  // Next-state: capture on en, remember sel, count select transitions with saturation
  always_comb begin
    s_reg_d = s_reg_q;
    valid_d = valid_q;
    sel_d_d = sel;
    cnt_d   = cnt_q;
    if (en) begin
      s_reg_d = S;
      valid_d = 1'b1;
    end
    if ((sel != sel_d_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; synchronous reset wins over capture and counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg_q <= '0;
      valid_q <= 1'b0;
      sel_d_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s_reg_q <= s_reg_d;
      valid_q <= valid_d;
      sel_d_q <= sel_d_d;
      cnt_q   <= cnt_d;
    end
  end

  assign S_q         = s_reg_q;
  assign S_valid     = valid_q;
  assign sel_changes = cnt_q;

endmodule

// File: tb/tb_mux_2v1.sv
// tb/tb_mux_2v1.sv - directed self-checking bench for mux_2v1

module tb_mux_2v1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        en;
  logic        a1, b1;
  logic [7:0]  a8, b8;

  logic        s_a, sq_a, v_a;
  logic [15:0] cnt_a;
  logic [7:0]  s_b, sq_b;
  logic        v_b;
  logic [15:0] cnt_b;
  logic        s_c, sq_c, v_c;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_2v1 #(.WIDTH(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .sel(sel), .en(en),
    .S(s_a), .S_q(sq_a), .S_valid(v_a), .sel_changes(cnt_a)
  );

  mux_2v1 #(.WIDTH(8), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .sel(sel), .en(en),
    .S(s_b), .S_q(sq_b), .S_valid(v_b), .sel_changes(cnt_b)
  );

  mux_2v1 #(.WIDTH(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .sel(sel), .en(en),
    .S(s_c), .S_q(sq_c), .S_valid(v_c), .sel_changes(cnt_c)
  );

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; sel = 1'b0;
    edge_step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; sel = 1'b1; a1 = 1'b0; b1 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    edge_step();
    n_checks++; if (sq_a !== 1'b0)  begin n_fail++; $display("FAIL reset_sq_a got %b want 0", sq_a); end
    n_checks++; if (v_a !== 1'b0)   begin n_fail++; $display("FAIL reset_valid_a got %b want 0", v_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_a got %0d want 0", cnt_a); end
    n_checks++; if (sq_b !== 8'h00) begin n_fail++; $display("FAIL reset_sq_b got %h want 00", sq_b); end
    n_checks++; if (s_b !== 8'h22)  begin n_fail++; $display("FAIL reset_s_b_tracks got %h want 22", s_b); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; sel = 1'b0;
  endtask

  task automatic test_comb();
    logic [1:0] ab;
    logic       exp;
    for (int i = 0; i < 8; i++) begin
      ab  = 2'(i >> 1);
      @(negedge clk);
      a1  = ab[1]; b1 = ab[0]; sel = i[0];
      exp = sel ? ab[0] : ab[1];
      #1;
      n_checks++;
      if (s_a !== exp) begin n_fail++; $display("FAIL comb A=%b B=%b sel=%b got %b want %b", a1, b1, sel, s_a, exp); end
    end
  endtask

  task automatic test_registered();
    do_reset();
    a1 = 1'b0; b1 = 1'b1; sel = 1'b1; en = 1'b1;
    edge_step();
    n_checks++; if (sq_a !== 1'b1)   begin n_fail++; $display("FAIL reg_capture got %b want 1", sq_a); end
    n_checks++; if (v_a !== 1'b1)    begin n_fail++; $display("FAIL reg_valid got %b want 1", v_a); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL reg_first_cnt got %0d want 1", cnt_a); end
    @(negedge clk);
    en = 1'b0; sel = 1'b0;
    edge_step();
    n_checks++; if (sq_a !== 1'b1)   begin n_fail++; $display("FAIL reg_hold got %b want 1", sq_a); end
    n_checks++; if (v_a !== 1'b1)    begin n_fail++; $display("FAIL reg_valid_hold got %b want 1", v_a); end
    n_checks++; if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL reg_cnt2 got %0d want 2", cnt_a); end
    @(negedge clk);
    sel = 1'b1;
    edge_step();
    n_checks++; if (cnt_a !== 16'd3) begin n_fail++; $display("FAIL reg_cnt3 got %0d want 3", cnt_a); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; sel = 1'b1; a1 = 1'b1; b1 = 1'b0;
    #1;
    n_checks++; if (sq_a !== 1'b1) begin n_fail++; $display("FAIL rst_edge_no_change got %b want 1", sq_a); end
    n_checks++; if (s_a !== 1'b0)  begin n_fail++; $display("FAIL rst_s_track1 got %b want 0", s_a); end
    edge_step();
    n_checks++; if (sq_a !== 1'b0)   begin n_fail++; $display("FAIL rst_sq got %b want 0", sq_a); end
    n_checks++; if (v_a !== 1'b0)    begin n_fail++; $display("FAIL rst_valid got %b want 0", v_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", cnt_a); end
    sel = 1'b0;
    #1;
    n_checks++; if (s_a !== 1'b1) begin n_fail++; $display("FAIL rst_s_track2 got %b want 1", s_a); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
  endtask

  task automatic test_counter();
    do_reset();
    en = 1'b0; sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_step();
      @(negedge clk);
      sel = ~sel;
    end
    n_checks++; if (cnt_a !== 16'd5) begin n_fail++; $display("FAIL cnt_five got %0d want 5", cnt_a); end
    n_checks++; if (cnt_c !== 2'd3)  begin n_fail++; $display("FAIL cnt_sat got %0d want 3", cnt_c); end
    n_checks++; if (v_a !== 1'b0)    begin n_fail++; $display("FAIL cnt_no_valid got %b want 0", v_a); end
    edge_step();
    n_checks++; if (cnt_a !== 16'd6) begin n_fail++; $display("FAIL cnt_six got %0d want 6", cnt_a); end
    n_checks++; if (cnt_c !== 2'd3)  begin n_fail++; $display("FAIL cnt_no_wrap got %0d want 3", cnt_c); end
    @(negedge clk);
    edge_step();
    n_checks++; if (cnt_a !== 16'd6) begin n_fail++; $display("FAIL cnt_stable got %0d want 6", cnt_a); end
  endtask

  task automatic test_width();
    do_reset();
    a8 = 8'hA5; b8 = 8'h3C; sel = 1'b0; en = 1'b0;
    #1;
    n_checks++; if (s_b !== 8'hA5) begin n_fail++; $display("FAIL width_s_a got %h want a5", s_b); end
    sel = 1'b1; en = 1'b1;
    #1;
    n_checks++; if (s_b !== 8'h3C) begin n_fail++; $display("FAIL width_s_b got %h want 3c", s_b); end
    edge_step();
    n_checks++; if (sq_b !== 8'h3C)  begin n_fail++; $display("FAIL width_sq got %h want 3c", sq_b); end
    n_checks++; if (cnt_b !== 16'd1) begin n_fail++; $display("FAIL width_simul_cnt got %0d want 1", cnt_b); end
    n_checks++; if (v_b !== 1'b1)    begin n_fail++; $display("FAIL width_valid got %b want 1", v_b); end
    @(negedge clk);
    sel = 1'b0; en = 1'b0;
    edge_step();
    n_checks++; if (sq_b !== 8'h3C)  begin n_fail++; $display("FAIL width_hold got %h want 3c", sq_b); end
    @(negedge clk);
    en = 1'b1;
    edge_step();
    n_checks++; if (sq_b !== 8'hA5)  begin n_fail++; $display("FAIL width_recap got %h want a5", sq_b); end
    n_checks++; if (cnt_b !== 16'd2) begin n_fail++; $display("FAIL width_cnt2 got %0d want 2", cnt_b); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1; sel = 1'b0; a8 = 8'h01;
    edge_step();
    @(negedge clk); a8 = 8'h02;
    edge_step();
    n_checks++; if (sq_b !== 8'h02) begin n_fail++; $display("FAIL b2b_second got %h want 02", sq_b); end
    @(negedge clk); a8 = 8'h03;
    edge_step();
    n_checks++; if (sq_b !== 8'h03) begin n_fail++; $display("FAIL b2b_third got %h want 03", sq_b); end
    n_checks++; if (cnt_b !== 16'd0) begin n_fail++; $display("FAIL b2b_cnt got %0d want 0", cnt_b); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; en = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    test_reset();
    test_comb();
    test_registered();
    test_mid_reset();
    test_counter();
    test_width();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
